// File: rtl/regfile_pkg.sv
// Shared widths, architectural register indices and data types for the
// scoreboarded register file.
package regfile_pkg;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned PEND_W = 2;
   localparam int unsigned NREAD  = 2;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_V0   = 2;
   localparam int unsigned REG_A0   = 4;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating pending-write counter for one architectural register.
module regfile_pend_ctr #(
   parameter int unsigned PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   input  logic              clr,
   output logic [PEND_W-1:0] cnt,
   output logic              nonzero,
   output logic              full
);
   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   // inc and dec together cancel: a write retires while a new writer issues
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && !dec && cnt != CNT_MAX) begin
         cnt <= cnt + PEND_W'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - PEND_W'(1);
      end
   end

   assign nonzero = (cnt != '0);
   assign full    = (cnt == CNT_MAX);
endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD bypassed read ports, one write port and a
// per-register pending-write scoreboard for decode-stage RAW detection.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = regfile_pkg::DATA_W,
   parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
   parameter int unsigned NREAD  = regfile_pkg::NREAD,
   parameter int unsigned PEND_W = regfile_pkg::PEND_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NREAD-1:0][ADDR_W-1:0]   rd_num,
   output logic [NREAD-1:0][DATA_W-1:0]   rd_data,
   output logic [NREAD-1:0]               rd_busy,
   input  logic                           wr_en,
   input  logic [ADDR_W-1:0]              wr_num,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic                           rsv_en,
   input  logic [ADDR_W-1:0]              rsv_num,
   output logic                           rsv_ready,
   input  logic                           flush,
   output logic [DATA_W-1:0]              dbg_v0,
   output logic [DATA_W-1:0]              dbg_a0
);
   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem     [DEPTH];
   logic [PEND_W-1:0] cnt     [DEPTH];
   logic              nonzero [DEPTH];
   logic              full    [DEPTH];
   logic [DEPTH-1:1]  inc;
   logic [DEPTH-1:1]  dec;
   logic              wr_live;
   logic              rsv_dec;

   assign wr_live = wr_en && (wr_num != '0);

   // Storage; r0 is never written so it always reads zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < int'(DEPTH); r++) mem[r] <= '0;
      end else if (wr_live) begin
         mem[wr_num] <= wr_data;
      end
   end

   assign cnt[0]     = '0;
   assign nonzero[0] = 1'b0;
   assign full[0]    = 1'b0;

   for (genvar r = 1; r < int'(DEPTH); r++) begin : g_ctr
      regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
         .clk     (clk),
         .rst     (rst),
         .inc     (inc[r]),
         .dec     (dec[r]),
         .clr     (flush),
         .cnt     (cnt[r]),
         .nonzero (nonzero[r]),
         .full    (full[r])
      );
   end

   // A write to a full register frees the slot the reservation needs
   assign rsv_dec   = wr_live && (wr_num == rsv_num) && nonzero[rsv_num];
   assign rsv_ready = rsv_en && ((rsv_num == '0) || !full[rsv_num] || rsv_dec);

   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 1; r < int'(DEPTH); r++) begin
         dec[r] = wr_live && (wr_num == ADDR_W'(r)) && nonzero[r];
         inc[r] = rsv_ready && (rsv_num == ADDR_W'(r));
      end
   end

   // Read ports: same-cycle bypass and busy net of a retiring write
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < int'(NREAD); i++) begin
         logic              hit;
         logic [PEND_W-1:0] left;
         hit        = wr_live && (wr_num == rd_num[i]);
         rd_data[i] = hit ? wr_data : mem[rd_num[i]];
         left       = cnt[rd_num[i]] - PEND_W'(hit && nonzero[rd_num[i]]);
         rd_busy[i] = (rd_num[i] != '0) && (left != '0);
      end
   end

   assign dbg_v0 = mem[ADDR_W'(REG_V0)];
   assign dbg_a0 = mem[ADDR_W'(REG_A0)];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb against an array-based model.
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int unsigned MAXC = 2**PEND_W - 1;

   logic                         clk;
   logic                         rst;
   logic [NREAD-1:0][ADDR_W-1:0] rd_num;
   logic [NREAD-1:0][DATA_W-1:0] rd_data;
   logic [NREAD-1:0]             rd_busy;
   logic                         wr_en;
   reg_idx_t                     wr_num;
   reg_data_t                    wr_data;
   logic                         rsv_en;
   reg_idx_t                     rsv_num;
   logic                         rsv_ready;
   logic                         flush;
   reg_data_t                    dbg_v0;
   reg_data_t                    dbg_a0;

   int unsigned m_mem [32];
   int unsigned m_cnt [32];
   int n_pass;
   int n_total;

   regfile_sb dut (
      .clk       (clk),
      .rst       (rst),
      .rd_num    (rd_num),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_num    (wr_num),
      .wr_data   (wr_data),
      .rsv_en    (rsv_en),
      .rsv_num   (rsv_num),
      .rsv_ready (rsv_ready),
      .flush     (flush),
      .dbg_v0    (dbg_v0),
      .dbg_a0    (dbg_a0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_rd(input int unsigned n);
      if (wr_en && n != 0 && int'(wr_num) == int'(n)) return wr_data;
      return m_mem[n];
   endfunction

   function automatic logic exp_busy(input int unsigned n);
      int unsigned hit;
      hit = (wr_en && n != 0 && int'(wr_num) == int'(n) && m_cnt[n] > 0) ? 1 : 0;
      return (n != 0) && (m_cnt[n] - hit != 0);
   endfunction

   function automatic logic exp_rsv();
      int unsigned n;
      n = rsv_num;
      if (!rsv_en) return 1'b0;
      if (n == 0) return 1'b1;
      return (m_cnt[n] < MAXC) || (wr_en && int'(wr_num) == int'(n) && m_cnt[n] > 0);
   endfunction

   task automatic check_all();
      for (int p = 0; p < int'(NREAD); p++) begin
         chk($sformatf("rd_data[%0d] r%0d", p, rd_num[p]), rd_data[p], exp_rd(rd_num[p]));
         chk($sformatf("rd_busy[%0d] r%0d", p, rd_num[p]), 32'(rd_busy[p]), 32'(exp_busy(rd_num[p])));
      end
      chk("rsv_ready", 32'(rsv_ready), 32'(exp_rsv()));
      chk("dbg_v0", dbg_v0, m_mem[REG_V0]);
      chk("dbg_a0", dbg_a0, m_mem[REG_A0]);
   endtask

   // Drive one cycle's inputs, then compare the combinational outputs
   task automatic apply(input int unsigned r0, input int unsigned r1,
                        input logic we, input int unsigned wn, input logic [31:0] wd,
                        input logic re, input int unsigned rn,
                        input logic fl, input logic rs);
      rd_num[0] = 5'(r0);
      rd_num[1] = 5'(r1);
      wr_en     = we;
      wr_num    = 5'(wn);
      wr_data   = wd;
      rsv_en    = re;
      rsv_num   = 5'(rn);
      flush     = fl;
      rst       = rs;
      #1;
      check_all();
   endtask

   // Clock edge: advance the model by the rules on the held inputs
   task automatic tick();
      logic acc;
      @(posedge clk);
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            m_mem[r] = 0;
            m_cnt[r] = 0;
         end
      end else begin
         acc = exp_rsv() && rsv_num != 0;
         if (wr_en && wr_num != 0) m_mem[wr_num] = wr_data;
         if (flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         end else begin
            if (wr_en && wr_num != 0 && m_cnt[wr_num] > 0) m_cnt[wr_num]--;
            if (acc) m_cnt[rsv_num]++;
         end
      end
      #1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      for (int r = 0; r < 32; r++) begin
         m_mem[r] = 32'hBAD0_0000 + r;
         m_cnt[r] = 0;
      end
      rd_num = '0; wr_en = 0; wr_num = '0; wr_data = '0;
      rsv_en = 0; rsv_num = '0; flush = 0; rst = 1;
      #1;
      tick();

      // After reset every register reads zero and nothing is busy
      for (int r = 0; r < 32; r += 2) begin
         apply(r, r + 1, 0, 0, 0, 0, 0, 0, 0);
         chk("reset_rd0", rd_data[0], 32'h0);
         chk("reset_rd1", rd_data[1], 32'h0);
         tick();
      end
      chk("reset_busy", 32'(rd_busy), 32'h0);

      apply(5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      chk("r5_bypass", rd_data[0], 32'hDEADBEEF);
      tick();
      apply(5, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("r5_stored", rd_data[0], 32'hDEADBEEF);
      tick();
      apply(0, 5, 1, 0, 32'h1234, 0, 0, 0, 0);
      chk("r0_bypass_zero", rd_data[0], 32'h0);
      tick();
      apply(0, 5, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_stored_zero", rd_data[0], 32'h0);
      tick();

      // Saturate r8 then drain with three writes
      for (int k = 0; k < 3; k++) begin
         apply(8, 0, 0, 0, 0, 1, 8, 0, 0);
         chk("r8_rsv_ok", 32'(rsv_ready), 32'h1);
         tick();
      end
      apply(8, 0, 0, 0, 0, 1, 8, 0, 0);
      chk("r8_rsv_full", 32'(rsv_ready), 32'h0);
      chk("r8_busy_full", 32'(rd_busy[0]), 32'h1);
      tick();
      for (int k = 0; k < 3; k++) begin
         apply(8, 0, 1, 8, 32'h80 + k, 0, 0, 0, 0);
         chk("r8_busy_drain", 32'(rd_busy[0]), (k == 2) ? 32'h0 : 32'h1);
         tick();
      end

      // Simultaneous reserve and write of r9 with one pending write
      apply(9, 0, 0, 0, 0, 1, 9, 0, 0);
      tick();
      apply(9, 0, 1, 9, 32'h99, 1, 9, 0, 0);
      chk("r9_rsv_wr_ready", 32'(rsv_ready), 32'h1);
      chk("r9_rsv_wr_busy", 32'(rd_busy[0]), 32'h0);
      tick();
      apply(9, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("r9_busy_next", 32'(rd_busy[0]), 32'h1);
      tick();

      // Flush clears reservations but keeps the concurrent write
      apply(3, 4, 0, 0, 0, 1, 3, 0, 0);
      tick();
      apply(3, 4, 0, 0, 0, 1, 4, 0, 0);
      tick();
      apply(3, 4, 1, 4, 32'h55, 0, 0, 1, 0);
      tick();
      apply(3, 4, 0, 0, 0, 0, 0, 0, 0);
      chk("flush_busy_r3", 32'(rd_busy[0]), 32'h0);
      chk("flush_busy_r4", 32'(rd_busy[1]), 32'h0);
      chk("flush_r4_data", rd_data[1], 32'h55);
      chk("flush_dbg_a0", dbg_a0, 32'h55);
      tick();

      // Reset mid-stream discards data and reservations
      apply(2, 0, 1, 2, 32'h7, 1, 2, 0, 0);
      tick();
      apply(2, 0, 0, 0, 0, 1, 2, 0, 1);
      tick();
      apply(2, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_r2_data", rd_data[0], 32'h0);
      chk("rst_dbg_v0", dbg_v0, 32'h0);
      chk("rst_r2_busy", 32'(rd_busy[0]), 32'h0);
      tick();

      // Random traffic concentrated on a few registers to force collisions
      for (int c = 0; c < 600; c++) begin
         apply($urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 7),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded register file for the pipelined MIPS core; successor to the single-issue register file. It provides NREAD combinational read ports with same-cycle write-to-read bypass and one synchronous write port, and keeps a per-register pending-write counter so decode can detect RAW hazards without a separate scoreboard. It sits between decode (reads, reservations) and writeback (writes), with debug taps for $v0/$a0 used by the syscall/test harness.

## Interface
- DATA_W, 32, data width of each register
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NREAD, 2, number of read ports
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2**PEND_W-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_num  in  NREAD×ADDR_W  read register indices
- rd_data  out  NREAD×DATA_W  read data (combinational)
- rd_busy  out  NREAD  register has an outstanding write not completed this cycle
- wr_en  in  1  write strobe (writeback)
- wr_num  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve (issue of an instruction that will write rsv_num)
- rsv_num  in  ADDR_W  reserved index
- rsv_ready  out  1  reservation of rsv_num accepted this cycle
- flush  in  1  clear all pending counters (pipeline flush); data untouched
- dbg_v0  out  DATA_W  register 2 contents (registered state, no bypass)
- dbg_a0  out  DATA_W  register 4 contents (registered state, no bypass)

## Operation
- Register 0: reads return 0; writes and reservations to index 0 ignored; counter 0 permanently 0, rsv_ready=1 for index 0.
- Read port i: if wr_en && wr_num==rd_num[i] && wr_num!=0, rd_data[i]=wr_data (bypass); else stored value.
- Write: on rising edge with wr_en, mem[wr_num]<=wr_data (wr_num!=0). Writes are accepted regardless of counter value.
- Counter per register cnt[r]:
  - write only: cnt-1 if cnt>0, else stays 0.
  - reserve only: cnt+1 if accepted.
  - write and reserve same register, same cycle: cnt unchanged (accepted if cnt<max or the write frees a slot, i.e. always accepted when a decrement occurs).
  - flush: all cnt<=0; overrides write/reserve that cycle. Data write still performed.
- rsv_ready = rsv_en && (cnt[rsv_num] < max || write-decrement of rsv_num this cycle); a rejected reservation changes nothing; decode must stall and retry.
- rd_busy[i] = (cnt[rd_num[i]] − writehit) != 0, where writehit=1 if wr_en targets rd_num[i] with cnt>0. Same-cycle reservations never affect rd_busy (instruction reading its own destination sees prior state). Index 0 never busy.

## Timing
- Read data and rd_busy: zero latency (combinational from rd_num, wr_*, state).
- Write visible to other reads next cycle via storage, same cycle via bypass.
- Counter update visible one cycle after the edge.
- Reset (rst high at rising edge): all registers 0, all counters 0; dbg_v0=dbg_a0=0, rd_data=0 and rd_busy=0 for all ports next cycle (absent bypass). rst overrides wr_en, rsv_en, flush in that cycle; reset mid-operation discards all in-flight reservations.
- rsv_ready and rd_busy are defined every cycle; no handshake stalls inside the block.

## Structure
- Package regfile_pkg: DATA_W, ADDR_W, PEND_W defaults; REG_ZERO=0, REG_V0=2, REG_A0=4 constants; typedef reg_idx_t, reg_data_t.
- Sub-module regfile_pend_ctr: one saturating up/down counter with inc, dec, clr inputs and nonzero/full outputs; instantiated 2**ADDR_W−1 times via generate.
- Storage and bypass muxes in the top module.

## Test plan
- Reset then read all ports from r0..r31 -> all 0, rd_busy=0, dbg_v0=dbg_a0=0.
- Write r5=0xDEADBEEF while rd_num[0]=5 same cycle -> rd_data[0]=0xDEADBEEF that cycle and thereafter; write r0=0x1234 -> r0 reads 0.
- Reserve r8 three times (PEND_W=2) -> rsv_ready 1,1,1; fourth reserve -> rsv_ready=0, cnt stays 3; three writes to r8 -> rd_busy drops during cycle of third write.
- Reserve r9 and write r9 same cycle with cnt=1 -> rsv_ready=1, cnt stays 1, rd_busy[0]=0 that cycle for rd_num=9, 1 next cycle.
- Reserve r3, r4; assert flush with wr_en to r4=0x55 -> next cycle rd_busy=0 for r3/r4, r4 reads 0x55, dbg_a0=0x55.
- Reserve r2 and write r2=7, then rst mid-stream -> next cycle r2=0, dbg_v0=0, rd_busy=0.
